// File: rtl/inv_rho_seq.sv
// inv_rho_seq
//   Sequential inverse of the Keccak-f[1600] Rho step. A captured 1600-bit
//   state is rotated in place, LANES_PER_CYCLE lanes per cycle, each 64-bit
//   lane rotated right by its Rho offset, restoring the pre-Rho state.
//
// Parameters
//   LANES_PER_CYCLE : lanes rotated per processing cycle (1, 5 or 25)
//
// Ports
//   inClk     in   1     clock, rising edge
//   inRstn    in   1     asynchronous active-low reset
//   inValid   in   1     upstream offers a state on inData
//   outReady  out  1     block can accept a state (IDLE only)
//   inData    in   1600  input state, lane i = inData[64*i +: 64], i = 5y+x
//   outValid  out  1     outData holds a complete result
//   inReady   in   1     downstream accepts outData
//   outData   out  1600  working register (valid only while outValid=1)
//   outBusy   out  1     lanes are being processed
//
// state  | meaning
// S_IDLE | waiting for inValid; outReady=1
// S_BUSY | rotating one lane group per cycle; outBusy=1
// S_DONE | result held on outData; outValid=1 until inReady

module inv_rho_seq #(
  parameter int LANES_PER_CYCLE = 1
) (
  input  logic          inClk,
  input  logic          inRstn,
  input  logic          inValid,
  output logic          outReady,
  input  logic [1599:0] inData,
  output logic          outValid,
  input  logic          inReady,
  output logic [1599:0] outData,
  output logic          outBusy
);

  generate
    if (!(LANES_PER_CYCLE == 1 || LANES_PER_CYCLE == 5 || LANES_PER_CYCLE == 25)) begin : g_bad_lpc
      $fatal(1, "inv_rho_seq: LANES_PER_CYCLE must be 1, 5 or 25");
    end
  endgenerate

  localparam logic [4:0] STEP = 5'(LANES_PER_CYCLE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t         state_q;
  logic [4:0]     idx_q;
  logic [1599:0]  work_q;
  logic [1599:0]  work_rot;
  logic [4:0]     lane;
  logic [10:0]    base;
  logic           out_ready_q;
  logic           out_valid_q;
  logic           out_busy_q;

  function automatic logic [5:0] rho_off(input logic [4:0] l);
    logic [5:0] r;
    case (l)
      5'd0:  r = 6'd0;
      5'd1:  r = 6'd1;
      5'd2:  r = 6'd62;
      5'd3:  r = 6'd28;
      5'd4:  r = 6'd27;
      5'd5:  r = 6'd36;
      5'd6:  r = 6'd44;
      5'd7:  r = 6'd6;
      5'd8:  r = 6'd55;
      5'd9:  r = 6'd20;
      5'd10: r = 6'd3;
      5'd11: r = 6'd10;
      5'd12: r = 6'd43;
      5'd13: r = 6'd25;
      5'd14: r = 6'd39;
      5'd15: r = 6'd41;
      5'd16: r = 6'd45;
      5'd17: r = 6'd15;
      5'd18: r = 6'd21;
      5'd19: r = 6'd8;
      5'd20: r = 6'd18;
      5'd21: r = 6'd2;
      5'd22: r = 6'd61;
      5'd23: r = 6'd56;
      5'd24: r = 6'd14;
      default: r = 6'd0;
    endcase
    return r;
  endfunction

  // A left shift by 64 (amt=0) yields zero, so r=0 passes the lane through.
  function automatic logic [63:0] rotr64(input logic [63:0] x, input logic [5:0] amt);
    return (x >> amt) | (x << (7'd64 - {1'b0, amt}));
  endfunction

  // Rotated copy of the working register: only the currently selected lane
  // group differs from work_q, so unprocessed lanes are never disturbed.
  always_comb begin
    work_rot = work_q;
    lane     = idx_q;
    base     = '0;
    for (int j = 0; j < LANES_PER_CYCLE; j++) begin
      lane = idx_q + 5'(j);
      base = {lane, 6'b0};
      work_rot[base +: 64] = rotr64(work_q[base +: 64], rho_off(lane));
    end
  end

  always_ff @(posedge inClk or negedge inRstn) begin
    if (!inRstn) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      work_q      <= '0;
      out_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      out_busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (inValid) begin
            work_q      <= inData;
            idx_q       <= '0;
            state_q     <= S_BUSY;
            out_ready_q <= 1'b0;
            out_busy_q  <= 1'b1;
          end
        end
        S_BUSY: begin
          work_q <= work_rot;
          // idx holds on the last group; it only returns to 0 on acceptance.
          if ((idx_q + STEP) == 5'd25) begin
            state_q     <= S_DONE;
            out_busy_q  <= 1'b0;
            out_valid_q <= 1'b1;
          end else begin
            idx_q <= idx_q + STEP;
          end
        end
        S_DONE: begin
          if (inReady) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            out_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_ready_q <= 1'b1;
          out_valid_q <= 1'b0;
          out_busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign outData  = work_q;
  assign outReady = out_ready_q;
  assign outValid = out_valid_q;
  assign outBusy  = out_busy_q;

endmodule

// File: tb/tb_inv_rho_seq.sv
module tb_inv_rho_seq;

  logic          clk;
  logic          rstn;
  logic          vld    [3];
  logic          rdy_up [3];
  logic [1599:0] din    [3];
  logic          dv     [3];
  logic          rdy_dn [3];
  logic [1599:0] dout   [3];
  logic          bsy    [3];

  int checks;
  int errors;
  int rofs [25];

  typedef struct {
    int            k;
    logic [1599:0] din;
    logic [1599:0] exp;
    int            hold;
    string         name;
  } vec_t;

  vec_t vt [6];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    inv_rho_seq #(.LANES_PER_CYCLE(g == 0 ? 1 : (g == 1 ? 5 : 25))) u_dut (
      .inClk    (clk),
      .inRstn   (rstn),
      .inValid  (vld[g]),
      .outReady (rdy_up[g]),
      .inData   (din[g]),
      .outValid (dv[g]),
      .inReady  (rdy_dn[g]),
      .outData  (dout[g]),
      .outBusy  (bsy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int nval(input int k);
    return (k == 0) ? 25 : ((k == 1) ? 5 : 1);
  endfunction

  // Rho offsets derived from the Keccak rule: walk (x,y) -> (y, 2x+3y)
  // starting at (1,0); step t gets offset (t+1)(t+2)/2 mod 64.
  task automatic build_offsets();
    int x, y, nx, ny;
    rofs[0] = 0;
    x = 1; y = 0;
    for (int t = 0; t < 24; t++) begin
      rofs[x + 5*y] = ((t + 1) * (t + 2) / 2) % 64;
      nx = y;
      ny = (2*x + 3*y) % 5;
      x = nx; y = ny;
    end
  endtask

  // Forward Rho (rhoFun): bit z of lane i moves to position (z + r[i]) mod 64.
  function automatic logic [1599:0] rho_fwd(input logic [1599:0] s);
    logic [1599:0] o;
    o = '0;
    for (int i = 0; i < 25; i++)
      for (int z = 0; z < 64; z++)
        o[64*i + ((z + rofs[i]) % 64)] = s[64*i + z];
    return o;
  endfunction

  function automatic logic [1599:0] rand_state();
    logic [1599:0] s;
    for (int i = 0; i < 50; i++) s[32*i +: 32] = $urandom;
    return s;
  endfunction

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b want %0b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic chk_state(input string name, input logic [1599:0] act, input logic [1599:0] exp);
    int bad;
    checks++;
    if (act !== exp) begin
      errors++;
      bad = 0;
      for (int i = 24; i >= 0; i--) if (act[64*i +: 64] !== exp[64*i +: 64]) bad = i;
      $display("FAIL %s: lane %0d got %h want %h", name, bad, act[64*bad +: 64], exp[64*bad +: 64]);
    end
  endtask

  task automatic chk_reset_outputs(input string name);
    for (int k = 0; k < 3; k++) begin
      chk_bit({name, "_ready"}, rdy_up[k], 1'b1);
      chk_bit({name, "_valid"}, dv[k], 1'b0);
      chk_bit({name, "_busy"}, bsy[k], 1'b0);
      chk_state({name, "_data"}, dout[k], '0);
    end
  endtask

  // One transaction on instance k. hold>0 keeps inReady low that many cycles
  // in DONE while offering another inValid, then releases with inValid high.
  task automatic txn(input int k, input logic [1599:0] s_in, input logic [1599:0] exp,
                     input int hold, input string name);
    int c, nb;
    @(negedge clk);
    chk_bit({name, "_idle_ready"}, rdy_up[k], 1'b1);
    vld[k] = 1'b1;
    din[k] = s_in;
    rdy_dn[k] = (hold == 0);
    @(negedge clk);
    vld[k] = 1'b0;
    din[k] = rand_state();
    c = 1;
    nb = 0;
    while (!dv[k] && c <= 40) begin
      if (bsy[k]) nb++;
      @(negedge clk);
      c++;
    end
    chk_int({name, "_latency"}, c, nval(k) + 1);
    chk_int({name, "_busy_cycles"}, nb, nval(k));
    chk_state({name, "_data"}, dout[k], exp);
    if (hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        vld[k] = 1'b1;
        din[k] = rand_state();
        @(negedge clk);
        chk_bit({name, "_hold_valid"}, dv[k], 1'b1);
        chk_bit({name, "_hold_ready"}, rdy_up[k], 1'b0);
        chk_state({name, "_hold_data"}, dout[k], exp);
      end
      vld[k] = 1'b1;
      rdy_dn[k] = 1'b1;
      @(negedge clk);
      vld[k] = 1'b0;
      chk_bit({name, "_release_ready"}, rdy_up[k], 1'b1);
      chk_bit({name, "_release_valid"}, dv[k], 1'b0);
      chk_bit({name, "_release_busy"}, bsy[k], 1'b0);
    end
  endtask

  initial begin
    logic [1599:0] a, e, s;
    int seen;
    checks = 0;
    errors = 0;
    build_offsets();

    // Reset held with inValid high and random data.
    rstn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      vld[k] = 1'b1;
      din[k] = rand_state();
      rdy_dn[k] = 1'b1;
    end
    repeat (3) begin
      @(negedge clk);
      chk_reset_outputs("reset");
    end
    for (int k = 0; k < 3; k++) vld[k] = 1'b0;
    rstn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_reset_outputs("post_reset");
    end

    // Directed vectors.
    a = '0; a[64*1 +: 64] = 64'h0000000000000001;
    e = '0; e[64*1 +: 64] = 64'h8000000000000000;
    vt[0] = '{k: 0, din: a, exp: e, hold: 0, name: "single_lane"};
    a = '0; a[64*24 +: 64] = 64'h0000000000004000; a[0 +: 64] = 64'hDEADBEEFCAFEF00D;
    e = '0; e[64*24 +: 64] = 64'h0000000000000001; e[0 +: 64] = 64'hDEADBEEFCAFEF00D;
    vt[1] = '{k: 0, din: a, exp: e, hold: 0, name: "offset_l1"};
    vt[2] = '{k: 1, din: a, exp: e, hold: 0, name: "offset_l5"};
    vt[3] = '{k: 2, din: a, exp: e, hold: 0, name: "offset_l25"};
    vt[4] = '{k: 1, din: a, exp: e, hold: 10, name: "backpressure"};
    a = '0; a[64*1 +: 64] = 64'h0000000000000001;
    e = '0; e[64*1 +: 64] = 64'h8000000000000000;
    vt[5] = '{k: 1, din: a, exp: e, hold: 0, name: "after_bp"};
    for (int v = 0; v < 6; v++) txn(vt[v].k, vt[v].din, vt[v].exp, vt[v].hold, vt[v].name);

    // Reset in cycle 12 of BUSY on the one-lane instance.
    s = rand_state();
    @(negedge clk);
    vld[0] = 1'b1;
    din[0] = rho_fwd(s);
    rdy_dn[0] = 1'b1;
    @(negedge clk);
    vld[0] = 1'b0;
    repeat (11) @(negedge clk);
    chk_bit("midrst_busy_before", bsy[0], 1'b1);
    rstn = 1'b0;
    #1;
    chk_reset_outputs("midrst_immediate");
    @(negedge clk);
    rstn = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (dv[0] || bsy[0]) seen++;
    end
    chk_int("midrst_no_activity", seen, 0);
    txn(0, rho_fwd(s), s, 0, "midrst_fresh");

    // Random round trips through the forward model, mixed parameters and backpressure.
    for (int n = 0; n < 999; n++) begin
      s = rand_state();
      txn(n % 3, rho_fwd(s), s, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0, "roundtrip");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
